// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and line-level constants for the UART TX path.
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
endpackage

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: registered parity bit, captured when a byte is accepted.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    input  logic                  load,
    output logic                  parity
);
    logic parity_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            parity_q <= 1'b0;
        else if (load)
            parity_q <= (par_typ == PAR_ODD) ? ~^data : ^data;
    end

    assign parity = parity_q;
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: one byte per handshake, sent LSB-first as start/data/[parity]/stop.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  load;
    logic                  parity;

    assign load = (state_q == IDLE) && data_valid;

    uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .clk     (clk),
        .reset   (reset),
        .data    (p_data),
        .par_typ (par_typ),
        .load    (load),
        .parity  (parity)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    if (data_valid) state_d = START;
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA:    if (cnt_q == LAST) state_d = par_en_q ? PARITY : STOP;
                     else cnt_d = cnt_q + CW'(1);
            PARITY:  state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered, so they are decoded from where the FSM is going.
        tx_d   = (state_d == START)  ? START_BIT :
                 (state_d == DATA)   ? data_q[cnt_d] :
                 (state_d == PARITY) ? parity : STOP_BIT;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            par_en_q <= 1'b0;
            tx_q     <= STOP_BIT;
            busy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            if (load) begin
                data_q   <= p_data;
                par_en_q <= par_en;
            end
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frame vectors plus back-to-back and mid-frame reset sequences.
module tb_uart_tx_serializer;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       pt;
        string      bits;
    } vec_t;

    vec_t vecs[9];

    uart_tx_serializer #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Bits are listed in line order, starting with the cycle after acceptance.
    task automatic run_frame(input string tag, input vec_t v);
        @(negedge clk);
        chk({tag, " idle tx"}, tx_out, 1'b1);
        chk({tag, " idle busy"}, busy, 1'b0);
        p_data = v.d; par_en = v.pe; par_typ = v.pt; data_valid = 1'b1;
        for (int i = 0; i < v.bits.len(); i++) begin
            @(negedge clk);
            chk($sformatf("%s bit%0d", tag, i), tx_out, v.bits[i] == "1");
            chk($sformatf("%s busy%0d", tag, i), busy, 1'b1);
            if (i == 0) begin
                data_valid = 1'b0;
                p_data = ~v.d; par_en = ~v.pe; par_typ = ~v.pt;
            end
        end
        @(negedge clk);
        chk({tag, " end tx"}, tx_out, 1'b1);
        chk({tag, " end busy"}, busy, 1'b0);
    endtask

    initial begin
        string b2b;
        vecs[0] = '{8'hA5, 1'b0, 1'b0, "0101001011"};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, "01010010101"};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, "01010010111"};
        vecs[3] = '{8'h01, 1'b1, 1'b1, "01000000001"};
        vecs[4] = '{8'h01, 1'b1, 1'b0, "01000000011"};
        vecs[5] = '{8'h34, 1'b0, 1'b0, "0001011001"};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, "01111111111"};
        vecs[7] = '{8'h00, 1'b1, 1'b0, "00000000001"};
        vecs[8] = '{8'h5A, 1'b1, 1'b1, "00101101011"};

        reset = 1'b0; p_data = 8'h00; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset tx", tx_out, 1'b1);
        chk("reset busy", busy, 1'b0);
        reset = 1'b1;

        for (int k = 0; k < 8; k++) run_frame($sformatf("v%0d", k), vecs[k]);

        // Controller advancing on !busy; a stray 0xFF strobe lands mid-frame.
        b2b = {"00010110011", "1", "00100100001"};
        @(negedge clk);
        p_data = 8'h34; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
        begin
            bit sent2 = 1'b0;
            for (int c = 0; c < b2b.len(); c++) begin
                @(negedge clk);
                chk($sformatf("b2b tx%0d", c), tx_out, b2b[c] == "1");
                chk($sformatf("b2b busy%0d", c), busy, c != 11);
                data_valid = 1'b0;
                if (!busy && !sent2) begin
                    p_data = 8'h12; data_valid = 1'b1; sent2 = 1'b1;
                end else if (c == 4) begin
                    p_data = 8'hFF; data_valid = 1'b1;
                end
            end
        end
        @(negedge clk);
        chk("b2b end tx", tx_out, 1'b1);
        chk("b2b end busy", busy, 1'b0);

        // Abort a frame during data bit 4, then send a clean frame.
        @(negedge clk);
        p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst bit4 tx", tx_out, 1'b0);
        chk("rst bit4 busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("rst async tx", tx_out, 1'b1);
        chk("rst async busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst idle tx", tx_out, 1'b1);
        chk("rst idle busy", busy, 1'b0);
        run_frame("post_rst", vecs[8]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
